clock_period_meter: RTL and testbench

Measures the period and high time of a slow digital signal, such as the output of the on-chip clock divider, in cycles of the system clock. It also reports the divider `scale` setting that would produce the measured waveform. The block is the receive-side counterpart of the divider and serves as an on-die self-check and loopback measurement unit. It sits beside the divider inside the top-level tile.

---
 rtl/clock_period_meter.sv | 186 ++++++++++++++++++
 tb/tb_clock_period_meter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_period_meter.sv
// clock_period_meter: measures the period and high time of a slow signal
// in clk_in cycles, and reports the matching divider scale setting.
// Optional feature macro: CLOCK_PERIOD_METER_CONTINUOUS_EN (free-running
// back-to-back measurements after a single start).
module clock_period_meter #(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             sig_in,
   input  logic             start,
   output logic             busy,
   output logic             valid,
   output logic             overflow,
   output logic [CNT_W-1:0] period_out,
   output logic [CNT_W-1:0] high_out,
   output logic [7:0]       scale_est
);

   localparam int unsigned SCALE_W = 8;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_MAX - CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARM     = 2'd1,
      S_MEASURE = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                 prev_q;
   logic [CNT_W-1:0]     period_cnt_q, period_cnt_d;
   logic [CNT_W-1:0]     high_cnt_q, high_cnt_d;
   logic [CNT_W-1:0]     period_q, period_d;
   logic [CNT_W-1:0]     high_q, high_d;
   logic [SCALE_W-1:0]   scale_q, scale_d;
   logic                 ovf_q, ovf_d;
   logic                 valid_q, valid_d;
   logic                 busy_q, busy_d;
   logic                 sync_lvl;
   logic                 rise;

   assign sync_lvl = sync_q[SYNC_STAGES-1];
   assign rise     = sync_lvl & ~prev_q;

   assign busy       = busy_q;
   assign valid      = valid_q;
   assign overflow   = ovf_q;
   assign period_out = period_q;
   assign high_out   = high_q;
   assign scale_est  = scale_q;

   // Synchroniser and previous-sample register; prev resets high so reset never looks like an edge
   always_ff @(posedge clk_in) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
         prev_q <= sync_lvl;
      end
   end

   // State, counter and result registers
   always_ff @(posedge clk_in) begin
      if (rst) begin
         state_q      <= S_IDLE;
         period_cnt_q <= '0;
         high_cnt_q   <= '0;
         period_q     <= '0;
         high_q       <= '0;
         scale_q      <= '0;
         ovf_q        <= 1'b0;
         valid_q      <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         period_cnt_q <= period_cnt_d;
         high_cnt_q   <= high_cnt_d;
         period_q     <= period_d;
         high_q       <= high_d;
         scale_q      <= scale_d;
         ovf_q        <= ovf_d;
         valid_q      <= valid_d;
         busy_q       <= busy_d;
      end
   end

   // Next-state, counting, timeout and result latch
   always_comb begin
      state_d      = state_q;
      period_cnt_d = period_cnt_q;
      high_cnt_d   = high_cnt_q;
      period_d     = period_q;
      high_d       = high_q;
      ovf_d        = ovf_q;
      valid_d      = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d      = S_ARM;
               period_cnt_d = '0;
               high_cnt_d   = '0;
            end
         end
         S_ARM: begin
            if (rise) begin
               state_d      = S_MEASURE;
               period_cnt_d = CNT_ONE;
               high_cnt_d   = CNT_ONE;
            end else if (period_cnt_q >= CNT_LAST) begin
               period_d = CNT_MAX;
               high_d   = high_cnt_q;
               ovf_d    = 1'b1;
               valid_d  = 1'b1;
`ifdef CLOCK_PERIOD_METER_CONTINUOUS_EN
               state_d      = S_ARM;
               period_cnt_d = '0;
               high_cnt_d   = '0;
`else
               state_d      = S_IDLE;
`endif
            end else begin
               period_cnt_d = period_cnt_q + CNT_ONE;
            end
         end
         S_MEASURE: begin
            if (rise) begin
               period_d = period_cnt_q;
               high_d   = high_cnt_q;
               ovf_d    = 1'b0;
               valid_d  = 1'b1;
`ifdef CLOCK_PERIOD_METER_CONTINUOUS_EN
               // the terminating edge opens the next period
               state_d      = S_MEASURE;
               period_cnt_d = CNT_ONE;
               high_cnt_d   = CNT_ONE;
`else
               state_d      = S_IDLE;
`endif
            end else if (period_cnt_q >= CNT_LAST) begin
               period_d = CNT_MAX;
               high_d   = high_cnt_q;
               ovf_d    = 1'b1;
               valid_d  = 1'b1;
`ifdef CLOCK_PERIOD_METER_CONTINUOUS_EN
               state_d      = S_ARM;
               period_cnt_d = '0;
               high_cnt_d   = '0;
`else
               state_d      = S_IDLE;
`endif
            end else begin
               period_cnt_d = period_cnt_q + CNT_ONE;
               if (sync_lvl && (high_cnt_q != CNT_MAX)) begin
                  high_cnt_d = high_cnt_q + CNT_ONE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // Scale estimate tracks the high-time result: high-1, saturated to 255, 0 for no high time
   always_comb begin
      scale_d = scale_q;
      if (valid_d) begin
         if (high_d == '0) begin
            scale_d = '0;
         end else if (high_d >= CNT_W'(256)) begin
            scale_d = SCALE_W'(255);
         end else begin
            scale_d = SCALE_W'(high_d - CNT_ONE);
         end
      end
   end

endmodule

// File: tb/tb_clock_period_meter.sv
// Self-checking bench for clock_period_meter: a 16-bit instance for normal
// measurements and a 9-bit instance for the timeout case.
module tb_clock_period_meter;

   logic        clk_in = 1'b0;
   logic        rst;
   logic        sig_in;
   logic        start;
   logic        start9;

   logic        busy, valid, overflow;
   logic [15:0] period_out, high_out;
   logic [7:0]  scale_est;
   logic        busy9, valid9, overflow9;
   logic [8:0]  period9, high9;
   logic [7:0]  scale9;

   int n_checks = 0;
   int n_pass   = 0;

   // waveform generator settings
   int  hi_len   = 4;
   int  lo_len   = 4;
   int  ph       = 0;
   bit  gen_on   = 1'b0;
   logic stuck_val = 1'b0;

   int  vcount  = 0;
   int  vcount9 = 0;

   always #5 clk_in = ~clk_in;

   clock_period_meter #(.CNT_W(16), .SYNC_STAGES(2)) u_dut (
      .clk_in(clk_in), .rst(rst), .sig_in(sig_in), .start(start),
      .busy(busy), .valid(valid), .overflow(overflow),
      .period_out(period_out), .high_out(high_out), .scale_est(scale_est)
   );

   clock_period_meter #(.CNT_W(9), .SYNC_STAGES(2)) u_dut9 (
      .clk_in(clk_in), .rst(rst), .sig_in(sig_in), .start(start9),
      .busy(busy9), .valid(valid9), .overflow(overflow9),
      .period_out(period9), .high_out(high9), .scale_est(scale9)
   );

   // synchronous periodic waveform, updated just after each rising clock edge
   initial begin
      sig_in = 1'b0;
      forever begin
         @(posedge clk_in);
         #1;
         if (gen_on) begin
            sig_in = (ph < hi_len) ? 1'b1 : 1'b0;
            ph = ph + 1;
            if (ph >= hi_len + lo_len) ph = 0;
         end else begin
            sig_in = stuck_val;
         end
      end
   end

   // running count of result pulses
   always @(negedge clk_in) begin
      if (valid)  vcount  <= vcount + 1;
      if (valid9) vcount9 <= vcount9 + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      else n_pass++;
   endtask

   task automatic set_wave(input int hi, input int lo);
      hi_len = hi;
      lo_len = lo;
      ph     = 0;
      gen_on = 1'b1;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk_in);
   endtask

   // one-cycle start pulse on the 16-bit instance; returns just after the sampling edge
   task automatic pulse_start();
      @(posedge clk_in); #1 start = 1'b1;
      @(posedge clk_in); #1 start = 1'b0;
   endtask

   // reference model: a periodic wave with hi/lo cycles gives period hi+lo, high hi,
   // scale = hi-1 capped at 255, no overflow, exactly one result
   task automatic measure(input string tag, input int hi, input int lo);
      int base, n;
      bit seen;
      int exp_scale;
      set_wave(hi, lo);
      cycles(2 * (hi + lo) + 8);
      base = vcount;
      pulse_start();
      @(negedge clk_in);
      check_eq({tag, "_busy"}, 32'(busy), 32'd1);
      seen = 1'b0;
      for (n = 0; n < 3 * (hi + lo) + 20; n++) begin
         @(negedge clk_in);
         if (valid) begin
            seen = 1'b1;
            break;
         end
      end
      check_eq({tag, "_seen"}, 32'(seen), 32'd1);
      exp_scale = (hi - 1 > 255) ? 255 : hi - 1;
      check_eq({tag, "_period"}, 32'(period_out), 32'(hi + lo));
      check_eq({tag, "_high"},   32'(high_out),   32'(hi));
      check_eq({tag, "_scale"},  32'(scale_est),  32'(exp_scale));
      check_eq({tag, "_ovf"},    32'(overflow),   32'd0);
      check_eq({tag, "_busy_off"}, 32'(busy), 32'd0);
      cycles(20);
      check_eq({tag, "_nvalid"}, 32'(vcount - base), 32'd1);
   endtask

   initial begin
      int lat, base, base9, hi, lo;
      bit seen;
      rst = 1'b1;
      start = 1'b0;
      start9 = 1'b0;

      // reset with sig_in held high
      gen_on = 1'b0;
      stuck_val = 1'b1;
      cycles(20);
      @(negedge clk_in);
      check_eq("rst_nvalid", 32'(vcount + vcount9), 32'd0);
      check_eq("rst_busy",   32'(busy),       32'd0);
      check_eq("rst_ovf",    32'(overflow),   32'd0);
      check_eq("rst_period", 32'(period_out), 32'd0);
      check_eq("rst_high",   32'(high_out),   32'd0);
      check_eq("rst_scale",  32'(scale_est),  32'd0);
      check_eq("rst_busy9",  32'(busy9),      32'd0);
      @(posedge clk_in); #1 rst = 1'b0;
      cycles(5);
      check_eq("idle_nvalid", 32'(vcount + vcount9), 32'd0);

      // directed cases from the divider
      measure("s3",   4,   4);
      measure("s255", 256, 256);
      measure("h300", 300, 300);
      measure("min",  1,   1);

      // randomized waveforms
      for (int i = 0; i < 6; i++) begin
         hi = $urandom_range(1, 300);
         lo = $urandom_range(1, 300);
         measure("rnd", hi, lo);
      end

      // timeout in ARM on the 9-bit instance with sig_in stuck low
      gen_on = 1'b0;
      stuck_val = 1'b0;
      cycles(10);
      base9 = vcount9;
      @(posedge clk_in); #1 start9 = 1'b1;
      @(posedge clk_in); #1 start9 = 1'b0;
      seen = 1'b0;
      lat = 0;
      for (int n = 0; n < 700; n++) begin
         @(negedge clk_in);
         lat++;
         if (valid9) begin
            seen = 1'b1;
            break;
         end
      end
      check_eq("to_seen",   32'(seen),      32'd1);
      check_eq("to_lat",    32'(lat - 1),   32'd511);
      check_eq("to_ovf",    32'(overflow9), 32'd1);
      check_eq("to_period", 32'(period9),   32'h1FF);
      check_eq("to_high",   32'(high9),     32'd0);
      check_eq("to_scale",  32'(scale9),    32'd0);
      check_eq("to_busy",   32'(busy9),     32'd0);
      cycles(10);
      check_eq("to_nvalid", 32'(vcount9 - base9), 32'd1);

      // a normal result on the 9-bit instance clears overflow
      set_wave(4, 4);
      cycles(20);
      @(posedge clk_in); #1 start9 = 1'b1;
      @(posedge clk_in); #1 start9 = 1'b0;
      cycles(30);
      @(negedge clk_in);
      check_eq("to_clr_ovf",    32'(overflow9), 32'd0);
      check_eq("to_clr_period", 32'(period9),   32'd8);

      // reset during MEASURE aborts with no result
      set_wave(40, 40);
      cycles(170);
      base = vcount;
      pulse_start();
      seen = 1'b0;
      for (int n = 0; n < 200; n++) begin
         @(posedge clk_in); #2;
         if (sig_in) begin
            seen = 1'b1;
            break;
         end
      end
      check_eq("ab_edge_seen", 32'(seen), 32'd1);
      cycles(10);
      #1 rst = 1'b1;
      @(posedge clk_in); #1 rst = 1'b0;
      @(negedge clk_in);
      check_eq("ab_busy",   32'(busy),       32'd0);
      check_eq("ab_period", 32'(period_out), 32'd0);
      check_eq("ab_high",   32'(high_out),   32'd0);
      check_eq("ab_scale",  32'(scale_est),  32'd0);
      cycles(300);
      check_eq("ab_nvalid", 32'(vcount - base), 32'd0);

`ifndef CLOCK_PERIOD_METER_CONTINUOUS_EN
      // second start while busy is ignored: a single result
      set_wave(10, 10);
      cycles(50);
      base = vcount;
      pulse_start();
      cycles(5);
      #1 start = 1'b1;
      @(posedge clk_in); #1 start = 1'b0;
      cycles(100);
      @(negedge clk_in);
      check_eq("dbl_nvalid", 32'(vcount - base), 32'd1);
      check_eq("dbl_period", 32'(period_out),   32'd20);
      check_eq("dbl_high",   32'(high_out),     32'd10);
      check_eq("dbl_busy",   32'(busy),         32'd0);
`else
      // continuous mode: a result every period, period 6
      set_wave(3, 3);
      cycles(20);
      pulse_start();
      lat = -1;
      for (int k = 0; k < 5; k++) begin
         seen = 1'b0;
         for (int n = 0; n < 40; n++) begin
            @(negedge clk_in);
            if (lat >= 0) lat++;
            if (valid) begin
               seen = 1'b1;
               break;
            end
         end
         check_eq("cont_seen", 32'(seen), 32'd1);
         if (k > 0) begin
            check_eq("cont_period",  32'(period_out), 32'd6);
            check_eq("cont_high",    32'(high_out),   32'd3);
            check_eq("cont_spacing", 32'(lat),        32'd6);
         end
         lat = 0;
      end
      check_eq("cont_busy", 32'(busy), 32'd1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
